mem64_writeback: RTL
====================

MEM64_WRITEBACK -- requirements
Module: mem64_writeback

Interface
REQ-001 Parameter AW, default 18, SRAM word-address width.
REQ-002 Parameter DW, default 16, data word width.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-005 start  input  1  request to write the 8x8 block buffer to SRAM.
REQ-006 base_addr  input  AW  SRAM word address of element [0][0], captured when start is accepted.
REQ-007 ld_en  input  1  load strobe writing ld_data into the block buffer.
REQ-008 ld_row, ld_col  input  3 each  buffer row/column index for the load.
REQ-009 ld_data  input  DW  word loaded into buffer[ld_row][ld_col].
REQ-010 sram_ready  input  1  SRAM accepts the presented write this cycle.
REQ-011 w_en  output  1  write request valid.
REQ-012 w_addr  output  AW  SRAM write address.
REQ-013 w_data  output  DW  SRAM write data.
REQ-014 busy  output  1  high while in WRITE or DONE state.
REQ-015 done  output  1  one-cycle pulse after the 64th accepted write.

Function
REQ-016 Block SHALL hold an internal 8x8 buffer of DW-bit words, index = row*8+col (0..63).
REQ-017 FSM SHALL have states IDLE, WRITE, DONE; IDLE -> WRITE on start=1; WRITE -> DONE when the write at index 63 is accepted; DONE -> IDLE unconditionally after one cycle.
REQ-018 In IDLE, start=1 SHALL latch base_addr and clear the 6-bit index counter on the same edge.
REQ-019 start SHALL be ignored while busy=1; no restart, no re-latch of base_addr.
REQ-020 In WRITE, w_en SHALL be 1, w_addr SHALL be (latched base + index) mod 2^AW, w_data SHALL be buffer[index/8][index%8]; outputs are a combinational function of registered state.
REQ-021 A write is accepted on an edge where w_en=1 and sram_ready=1; index SHALL increment by 1 only on acceptance.
REQ-022 While sram_ready=0, w_en, w_addr and w_data SHALL hold stable.
REQ-023 Outside WRITE, w_en SHALL be 0; w_addr and w_data SHALL be 0.
REQ-024 done SHALL be 1 exactly in the DONE state cycle, else 0.
REQ-025 With sram_ready held 1: start sampled at edge N -> writes presented in cycles N+1..N+64 -> done high in cycle N+65 -> IDLE with busy=0 in cycle N+66.
REQ-026 Addresses SHALL wrap modulo 2^AW when base+index exceeds 2^AW-1; no error indication.
REQ-027 ld_en=1 in IDLE SHALL write ld_data to buffer[ld_row][ld_col] on the edge; ld_en while busy=1 SHALL be ignored.
REQ-028 ld_en and start on the same IDLE edge: the load SHALL complete, and the subsequent write sequence SHALL use the updated word.
REQ-029 Back-to-back start SHALL be accepted no earlier than the first IDLE cycle after DONE.

Reset
REQ-030 reset=1 SHALL force state IDLE, index 0, latched base 0, w_en=0, w_addr=0, w_data=0, busy=0, done=0 on the next edge, taking priority over all other inputs.
REQ-031 reset mid-WRITE SHALL abort the sequence with no done pulse; remaining words are not written.
REQ-032 Buffer contents SHALL be unaffected by reset.

Verification
REQ-033 Load buffer[r][c]=r*8+c, base_addr=0x00100, start, sram_ready=1 -> 64 writes addr 0x00100..0x0013F, data 0..63, done in cycle 65 after start.
REQ-034 Same load, sram_ready toggling 1,0,1,0 -> each word held during stall, 64 distinct accepted writes in order, done after the last acceptance only.
REQ-035 base_addr=0x3FFF8 -> addresses 0x3FFF8..0x3FFFF then 0x00000..0x00037, no gaps.
REQ-036 Assert start and ld_en (row 7, col 7, data 0xBEEF) during WRITE -> no restart, buffer unchanged, write of index 63 carries original value.
REQ-037 reset asserted after the 10th accepted write -> next cycle w_en=0, busy=0, done never pulses; new start then writes all 64 from index 0.
REQ-038 ld_en (row 0, col 0, 0xA5A5) and start on same edge -> first write data = 0xA5A5.

Source files
------------

// File: rtl/mem64_writeback.sv
// Streams an 8x8 block buffer to SRAM as 64 consecutive word writes from a
// latched base address, with a ready/valid style stall on the SRAM side.
module mem64_writeback #(
    parameter int AW = 18,
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          ld_en,
    input  logic [2:0]    ld_row,
    input  logic [2:0]    ld_col,
    input  logic [DW-1:0] ld_data,
    input  logic          sram_ready,
    output logic          w_en,
    output logic [AW-1:0] w_addr,
    output logic [DW-1:0] w_data,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [5:0]    idx_q;
    logic [AW-1:0] base_q;
    logic [DW-1:0] mem [64];
    logic          accept;

    assign accept = (state_q == WRITE) && sram_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = WRITE;
            WRITE:   if (accept && idx_q == 6'd63) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                idx_q  <= '0;
                base_q <= base_addr;
            end else if (accept) begin
                idx_q <= idx_q + 6'd1;
            end
        end
    end

    // Buffer is not reset; loads are only honoured while idle.
    always_ff @(posedge clock) begin
        if (!reset && ld_en && state_q == IDLE)
            mem[{ld_row, ld_col}] <= ld_data;
    end

    always_comb begin
        w_en   = (state_q == WRITE);
        w_addr = '0;
        w_data = '0;
        if (w_en) begin
            w_addr = base_q + AW'(idx_q);
            w_data = mem[idx_q];
        end
    end

    assign busy = (state_q == WRITE) || (state_q == DONE);
    assign done = (state_q == DONE);

endmodule
